// File: rtl/irq_timer_if.sv
// Bus-side signals of the memory-mapped interrupt timer: word-select, write strobe/data,
// combinational read data and the interrupt request to the CP0 HWInt input.
interface irq_timer_if #(
   parameter int unsigned WIDTH = 32
);
   logic [1:0]       addr;
   logic             we;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd;
   logic             irq;

   modport master (
      output addr,
      output we,
      output wd,
      input  rd,
      input  irq
   );

   modport slave (
      input  addr,
      input  we,
      input  wd,
      output rd,
      output irq
   );
endinterface

// File: rtl/irq_timer.sv
// Down-counting timer: counts PRESET to 0, then flags an interrupt; one-shot (held flag) or
// auto-reload (single-cycle flag). Registers: CTRL (EN, MODE, IM), PRESET, read-only COUNT.
module irq_timer #(
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   irq_timer_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   state_e           state_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-1:0] preset_q;
   logic [WIDTH-1:0] count_q;
   logic             irq_flag_q;

   logic en;
   logic im;
   logic auto_reload;
   logic cfg_wr;

   assign en          = ctrl_q[0];
   assign im          = ctrl_q[3];
   // MODE 1x falls back to one-shot.
   assign auto_reload = (ctrl_q[2:1] == 2'b01);
   assign cfg_wr      = bus.we && !bus.addr[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else if (cfg_wr) begin
         // Software config write overrides whatever the FSM would do on this edge.
         if (bus.addr[0]) begin
            preset_q <= bus.wd;
         end else begin
            ctrl_q <= bus.wd[3:0];
         end
         irq_flag_q <= 1'b0;
         state_q    <= StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (en) begin
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               count_q <= preset_q;
               state_q <= StCnt;
            end
            StCnt: begin
               if (!en) begin
                  state_q <= StIdle;
               end else if (count_q != '0) begin
                  count_q <= count_q - 1'b1;
               end else begin
                  irq_flag_q <= 1'b1;
                  state_q    <= StInt;
               end
            end
            StInt: begin
               if (auto_reload) begin
                  irq_flag_q <= 1'b0;
                  state_q    <= StLoad;
               end else begin
                  ctrl_q[0] <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.rd = '0;
      case (bus.addr)
         2'd0:    bus.rd[3:0] = ctrl_q;
         2'd1:    bus.rd      = preset_q;
         2'd2:    bus.rd      = count_q;
         default: bus.rd      = '0;
      endcase
   end

   assign bus.irq = im & irq_flag_q;

endmodule

// File: tb/tb_irq_timer.sv
// Bench for irq_timer: directed scenarios followed by random bus traffic, all checked against a
// cycle-count based timing model of the timer.
module tb_irq_timer;
   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;

   irq_timer_if #(.WIDTH(WIDTH)) bus ();

   irq_timer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   string phase  = "reset";

   // Model: timer described by edges elapsed (m_k) since the last config write.
   logic [3:0] m_ctrl;
   longint     m_preset;
   longint     m_base;
   longint     m_k;
   bit         m_run;

   function automatic bit m_mode1();
      return m_ctrl[2:1] == 2'b01;
   endfunction

   function automatic longint m_count();
      longint p;
      longint ph;
      p = m_preset;
      if (!m_run || m_k < 2) return m_base;
      if (m_mode1()) begin
         ph = ((m_k - 1) % (p + 3)) + 1;
         if (ph == 1 || ph == p + 3) return 0;
         return p - (ph - 2);
      end
      if (m_k <= p + 2) return p - (m_k - 2);
      return 0;
   endfunction

   function automatic bit m_flag();
      if (!m_run || m_k < m_preset + 3) return 1'b0;
      if (m_mode1()) return (m_k % (m_preset + 3)) == 0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_rd(logic [1:0] a);
      case (a)
         2'd0:    return {28'b0, m_ctrl};
         2'd1:    return 32'(m_preset);
         2'd2:    return 32'(m_count());
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl   = '0;
      m_preset = 0;
      m_base   = 0;
      m_k      = 0;
      m_run    = 1'b0;
   endtask

   task automatic model_edge(bit w, logic [1:0] a, logic [31:0] d);
      if (w && a < 2) begin
         m_base = m_count();
         if (a == 2'd0) m_ctrl = d[3:0];
         else           m_preset = longint'(d);
         m_k   = 0;
         m_run = m_ctrl[0];
      end else if (m_run) begin
         m_k++;
         if (!m_mode1() && m_k == m_preset + 4) m_ctrl[0] = 1'b0;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic peek(logic [1:0] a, output logic [31:0] v);
      bus.addr = a;
      #1;
      v = bus.rd;
   endtask

   task automatic check_all();
      logic [31:0] v;
      for (int a = 0; a < 4; a++) begin
         peek(2'(a), v);
         chk($sformatf("%s rd@%0d", phase, a), v, exp_rd(2'(a)));
      end
      chk($sformatf("%s irq", phase), {31'b0, bus.irq}, {31'b0, m_ctrl[3] & m_flag()});
   endtask

   task automatic tick(bit w, logic [1:0] a, logic [31:0] d);
      bus.addr = a;
      bus.we   = w;
      bus.wd   = d;
      @(posedge clk);
      model_edge(w, a, d);
      #1;
      bus.we = 1'b0;
      check_all();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 32'h0);
   endtask

   initial begin
      logic [31:0] v;
      int          pulses;
      logic [1:0]  ra;
      logic [31:0] rdat;

      bus.addr = '0;
      bus.we   = 1'b0;
      bus.wd   = '0;
      model_reset();

      // Reset state, then idle after release.
      #12;
      check_all();
      @(negedge clk);
      reset = 1'b1;
      phase = "idle";
      idle(10);

      // One-shot: PRESET=5, CTRL=0x9.
      phase = "mode0";
      tick(1'b1, 2'd1, 32'd5);
      tick(1'b1, 2'd0, 32'h9);
      idle(7);
      chk("mode0 irq before E0+8", {31'b0, bus.irq}, 32'd0);
      idle(1);
      chk("mode0 irq at E0+8", {31'b0, bus.irq}, 32'd1);
      idle(3);
      chk("mode0 irq held", {31'b0, bus.irq}, 32'd1);
      peek(2'd0, v);
      chk("mode0 ctrl EN cleared", v, 32'h8);
      tick(1'b1, 2'd0, 32'h0);
      chk("mode0 irq cleared by write", {31'b0, bus.irq}, 32'd0);

      // Auto-reload: PRESET=3, CTRL=0xB, period 6.
      phase  = "mode1";
      pulses = 0;
      tick(1'b1, 2'd1, 32'd3);
      tick(1'b1, 2'd0, 32'hB);
      for (int i = 0; i < 24; i++) begin
         tick(1'b0, 2'd0, 32'h0);
         if (bus.irq) pulses++;
      end
      chk("mode1 pulse count", 32'(pulses), 32'd4);

      // Masked: flag sets silently, a CTRL write clears it.
      phase = "mask";
      tick(1'b1, 2'd0, 32'h0);
      tick(1'b1, 2'd1, 32'd2);
      tick(1'b1, 2'd0, 32'h1);
      idle(6);
      peek(2'd2, v);
      chk("mask count reached 0", v, 32'd0);
      chk("mask irq low", {31'b0, bus.irq}, 32'd0);
      tick(1'b1, 2'd0, 32'h8);
      chk("mask irq after IM write", {31'b0, bus.irq}, 32'd0);
      tick(1'b1, 2'd0, 32'h9);
      idle(6);
      chk("unmasked irq", {31'b0, bus.irq}, 32'd1);

      // Write during INT cycle wins over the FSM.
      phase = "collide";
      tick(1'b1, 2'd0, 32'h0);
      tick(1'b1, 2'd1, 32'd2);
      tick(1'b1, 2'd0, 32'h9);
      idle(5);
      chk("INT cycle irq", {31'b0, bus.irq}, 32'd1);
      tick(1'b1, 2'd0, 32'hB);
      peek(2'd0, v);
      chk("INT write kept", v, 32'hB);
      chk("INT write clears irq", {31'b0, bus.irq}, 32'd0);

      // Freeze mid-count at 7, ignored COUNT writes, re-enable reloads.
      phase = "freeze";
      tick(1'b1, 2'd0, 32'h0);
      tick(1'b1, 2'd1, 32'd20);
      tick(1'b1, 2'd0, 32'h1);
      idle(15);
      peek(2'd2, v);
      chk("count at 7", v, 32'd7);
      tick(1'b1, 2'd0, 32'h0);
      idle(5);
      tick(1'b1, 2'd2, 32'h55);
      tick(1'b1, 2'd3, 32'hAA);
      peek(2'd2, v);
      chk("count frozen", v, 32'd7);
      tick(1'b1, 2'd0, 32'h1);
      idle(4);

      // PRESET all-ones: plain decrement.
      phase = "maxpreset";
      tick(1'b1, 2'd1, 32'hFFFF_FFFF);
      tick(1'b1, 2'd0, 32'h1);
      idle(10);
      peek(2'd2, v);
      chk("max preset count", v, 32'hFFFF_FFF7);

      // Asynchronous reset mid-count.
      phase = "areset";
      tick(1'b1, 2'd1, 32'd100);
      tick(1'b1, 2'd0, 32'hB);
      idle(52);
      peek(2'd2, v);
      chk("count near 50", v, 32'd50);
      reset = 1'b0;
      model_reset();
      check_all();
      reset = 1'b1;
      phase = "post-reset";
      idle(3);

      // Random bus traffic.
      phase = "random";
      for (int i = 0; i < 300; i++) begin
         ra = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            if (ra == 2'd1) rdat = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF
                                                               : 32'($urandom_range(0, 8));
            else            rdat = $urandom;
            tick(1'b1, ra, rdat);
         end else begin
            tick(1'b0, ra, $urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
